// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan driver: the segment
// vector type, the hex decode table (abcdefg, a = MSB, 0 = segment ON)
// and the all-segments-off pattern.
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-segment lookup driven by the package decode table.
module hex_to_seg
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver. A divider holds each digit slot
// for REFRESH_DIV cycles, the first BLANK_CYCLES of which are dark to
// suppress ghosting. New display data is staged in a pending buffer by
// 'load' and only promoted at a frame boundary so a frame never mixes
// old and new contents. All outputs are registered, one cycle behind the
// divider/index state.
// Optional feature: define SEVSEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic [6:0]            sevenSeg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   anodes,
    output logic                  frame_done
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [4*N_DIGITS-1:0] pend_value_q, pend_value_d;
    logic [N_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;

    logic [4*N_DIGITS-1:0] disp_value_q, disp_value_d;
    logic [N_DIGITS-1:0]   disp_en_q, disp_en_d;
    logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;

    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   anodes_q, anodes_d;
    logic                  frame_done_q, frame_done_d;

    logic [3:0]            sel_nibble;
    logic                  sel_en;
    logic                  sel_dp;
    logic                  sel_lzb;
    seg_t                  sel_seg;

    // Advance the divider and digit index; frame_done_q is registered from
    // the next state so it is high exactly while the final frame cycle runs
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        frame_done_d = (div_d == DIV_W'(REFRESH_DIV - 1)) &&
                       (idx_d == IDX_W'(N_DIGITS - 1));
    end

    // Stage loads in the pending buffer; promote only at a frame end, and a
    // load landing on the frame end supersedes whatever was pending
    always_comb begin
        pend_value_d = pend_value_q;
        pend_en_d    = pend_en_q;
        pend_dp_d    = pend_dp_q;
        pend_flag_d  = pend_flag_q;
        disp_value_d = disp_value_q;
        disp_en_d    = disp_en_q;
        disp_dp_d    = disp_dp_q;
        if (load) begin
            pend_value_d = value;
            pend_en_d    = digit_en;
            pend_dp_d    = dp_in;
            pend_flag_d  = 1'b1;
        end else if (frame_done_q && pend_flag_q) begin
            disp_value_d = pend_value_q;
            disp_en_d    = pend_en_q;
            disp_dp_d    = pend_dp_q;
            pend_flag_d  = 1'b0;
        end
    end

    // Pick the nibble, enable and decimal point of the digit being scanned
    always_comb begin
        sel_nibble = '0;
        sel_en     = 1'b0;
        sel_dp     = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nibble = disp_value_q[4*i +: 4];
                sel_en     = disp_en_q[i];
                sel_dp     = disp_dp_q[i];
            end
        end
    end

`ifdef SEVSEG_LZB_EN
    logic [N_DIGITS-1:0] lzb_mask;
    logic                lzb_run;

    // Walk down from the top digit: blanking continues while nibbles are
    // zero with no lit point, and digit 0 is never part of the run
    always_comb begin
        lzb_mask = '0;
        lzb_run  = 1'b1;
        sel_lzb  = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lzb_run     = lzb_run && (disp_value_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
            lzb_mask[i] = lzb_run;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_lzb = lzb_mask[i];
            end
        end
    end
`else
    assign sel_lzb = 1'b0;
`endif

    hex_to_seg u_hex_to_seg (
        .nibble (sel_nibble),
        .seg    (sel_seg)
    );

    // Output stage: dark during the ghost-blank window, otherwise select the
    // anode and show the decoded digit unless it is disabled or zero-blanked
    always_comb begin
        seg_d    = SEG_BLANK;
        dp_d     = 1'b1;
        anodes_d = '1;
        if (div_q >= DIV_W'(BLANK_CYCLES)) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                anodes_d[i] = (idx_q != IDX_W'(i));
            end
            if (sel_en && !sel_lzb) begin
                seg_d = sel_seg;
                dp_d  = !sel_dp;
            end
        end
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_en_q    <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_value_q <= '0;
            disp_en_q    <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            anodes_q     <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_en_q    <= pend_en_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            disp_value_q <= disp_value_d;
            disp_en_q    <= disp_en_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            anodes_q     <= anodes_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sevenSeg   = seg_q;
    assign dp         = dp_q;
    assign anodes     = anodes_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles each digit stays selected, minimum 4.
REQ-003 Parameter BLANK_CYCLES, default 16: inter-digit ghost-blank cycles at the start of each digit slot, less than REFRESH_DIV.
REQ-004 clk  input  1  system clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 value  input  4*N_DIGITS  hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-007 digit_en  input  N_DIGITS  per-digit enable; 0 blanks that digit.
REQ-008 dp_in  input  N_DIGITS  per-digit decimal point, 1 = lit.
REQ-009 load  input  1  single-cycle strobe; captures value, digit_en and dp_in into a pending buffer.
REQ-010 sevenSeg  output  7  segments abcdefg, a = MSB, 0 = ON.
REQ-011 dp  output  1  decimal point, 0 = ON.
REQ-012 anodes  output  N_DIGITS  digit select, one-hot-low, 0 = selected.
REQ-013 frame_done  output  1  one-cycle pulse when the last digit slot completes.

Function
REQ-014 A divider counter shall count 0..REFRESH_DIV-1 and wrap; at the wrap the digit index shall advance by one.
REQ-015 The digit index shall run 0..N_DIGITS-1 and wrap to 0; frame_done shall pulse in the cycle the index wraps.
REQ-016 While divider < BLANK_CYCLES, anodes shall be all 1 and sevenSeg/dp all 1.
REQ-017 Otherwise anodes[index] shall be 0, all other anodes 1, and sevenSeg shall hold the decoded display nibble.
REQ-018 Decode: 0 to 0000001, 1 to 1001111, 2 to 0010010, 3 to 0000110, 4 to 1001100, 5 to 0100100, 6 to 0100000, 7 to 0001111, 8 to 0000000, 9 to 0000100, A to 0001000, b to 1100000, C to 0110001, d to 1000010, E to 0110000, F to 0111000.
REQ-019 A digit with its display digit_en bit at 0 shall output sevenSeg = 1111111 and dp = 1, with its anode still selected.
REQ-020 On load, the pending buffer shall capture the inputs and set a pending flag.
REQ-021 The display register shall take the pending buffer only in the frame_done cycle, and only if the flag is set; the flag then clears, so a frame never mixes old and new data.
REQ-022 If load and frame_done coincide, the new inputs shall be captured as pending and transfer at the next frame end; the older pending data is discarded.
REQ-023 Multiple loads within one frame: the last one wins.
REQ-024 Outputs shall be registered; the decode-to-pin latency is one cycle after the index/divider state.

Reset
REQ-025 While rst_n = 0: divider = 0, index = 0, pending flag = 0, display and pending buffers = 0, digit_en buffers = all 0.
REQ-026 While rst_n = 0: anodes all 1, sevenSeg = 1111111, dp = 1, frame_done = 0.
REQ-027 Reset asserted mid-slot shall force the reset values immediately, without waiting for a clock edge.
REQ-028 After release, scanning restarts at digit 0 with a full blank period.

Configuration
REQ-029 Macro SEVSEG_LZB_EN, when defined, shall enable leading-zero blanking: any digit whose nibble is 0 and which has only zero nibbles above it (higher indices) shall be blanked as in REQ-019.
REQ-030 Under SEVSEG_LZB_EN, digit 0 shall never be blanked by leading-zero blanking.
REQ-031 Under SEVSEG_LZB_EN, a lit dp on a digit shall stop leading-zero blanking at that digit.
REQ-032 Without SEVSEG_LZB_EN, zeros shall always display, and no leading-zero logic shall be synthesised.

Structure
REQ-033 Package sevseg_pkg shall hold the segment typedef (logic [6:0]), the 16-entry decode constant table and the SEG_BLANK constant.
REQ-034 Sub-module hex_to_seg (combinational nibble-to-segment lookup using the package table) shall be instantiated once, on the selected nibble.

Verification
REQ-035 N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, load value=16'h12AF, digit_en=4'hF -> after the next frame_done, the slots show anodes 1110/F to 0111000, 1101/A to 0001000, 1011/2 to 0010010, 0111/1 to 1001111, with 2 blank cycles each.
REQ-036 Load 16'h1111, then load 16'h2222 mid-frame -> the current frame is all 1s, the next frame is all 2s, and 1111 never reappears.
REQ-037 load coincident with frame_done -> the data appears one full frame later.
REQ-038 digit_en=4'b0101 -> digits 1 and 3 output 1111111 in their slots while their anodes are still selected.
REQ-039 SEVSEG_LZB_EN defined, value=16'h0070 -> digits 3 and 2 blanked, digits 1 and 0 show 7 and 0; with the macro undefined -> 0070 shown.
REQ-040 rst_n pulled low mid-slot between clock edges -> anodes = 1111 and sevenSeg = 1111111 immediately; after release, the first selected anode is 1110 following 2 blank cycles.
